// File: rtl/stepper_motion_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stepper_motion_sequencer: Avalon-MM trapezoidal step/direction generator. |
// | Optional macro STEP_POSITION_COUNTER_EN enables register 6 (position).    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module stepper_motion_sequencer #(
  parameter int PULSE_WIDTH = 10
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ctrl_address,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  output logic        coe_step,
  output logic        coe_dir,
  output logic        coe_enable,
  output logic        ins_irq
);
  localparam logic [31:0]       c_MIN_FLOOR = 32'(2 * PULSE_WIDTH);
  localparam int                c_PW_W      = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [c_PW_W-1:0] c_PW_LOAD   = c_PW_W'(PULSE_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_CRUISE = 3'd2,
    S_DECEL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt, w_step_state;
  logic [31:0]       r_steps, r_start_period, r_min_period, r_accel;
  logic [31:0]       r_min_eff, r_period, r_ramp, r_remaining, r_timer;
  logic              r_ctrl_dir, r_enable, r_done, r_aborted;
  logic [c_PW_W-1:0] r_pulse_cnt;
  logic [31:0]       w_min_eff, w_first_period, w_load_period, w_period_nxt, w_ramp_nxt;
  logic [31:0]       w_remaining_nxt, w_position;
  logic              w_ctrl_wr, w_start, w_abort, w_status_clr, w_running, w_step;
  logic              w_cruise_first, w_busy;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] wd,
                                          input logic [3:0] be);
    logic [31:0] v;
    v = old_v;
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = wd[8*i +: 8];
    return v;
  endfunction

  function automatic logic [31:0] f_sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign w_ctrl_wr      = avs_ctrl_write && (avs_ctrl_address == 3'd4);
  assign w_start        = w_ctrl_wr && avs_ctrl_writedata[0] && (r_state == S_IDLE);
  assign w_abort        = w_ctrl_wr && avs_ctrl_writedata[1] && (r_state != S_IDLE);
  assign w_status_clr   = avs_ctrl_write && (avs_ctrl_address == 3'd5) && avs_ctrl_writedata[1];
  assign w_min_eff      = (r_min_period > c_MIN_FLOOR) ? r_min_period : c_MIN_FLOOR;
  assign w_first_period = (r_start_period > w_min_eff) ? r_start_period : w_min_eff;
  assign w_cruise_first = (r_accel == 32'd0) || (w_first_period == w_min_eff);
  assign w_load_period  = w_cruise_first ? w_min_eff : w_first_period;
  assign w_running      = (r_state == S_ACCEL) || (r_state == S_CRUISE) || (r_state == S_DECEL);
  assign w_step         = w_running && !w_abort && (r_remaining != 32'd0) && (r_timer == 32'd1);
  assign w_busy         = (r_state != S_IDLE);

  assign avs_ctrl_waitrequest = 1'b0;
  assign coe_enable           = r_enable;
  assign ins_irq              = r_done | r_aborted;

  // Per-step profile update; reaching zero remaining holds the state for one
  // cycle so DONE lands on the edge after the final rising edge.
  always_comb begin
    w_period_nxt    = r_period;
    w_ramp_nxt      = r_ramp;
    w_step_state    = r_state;
    w_remaining_nxt = r_remaining - 32'd1;
    if (r_state == S_ACCEL) begin
      if (r_accel >= (r_period - r_min_eff)) begin
        w_period_nxt = r_min_eff;
        w_step_state = S_CRUISE;
      end else begin
        w_period_nxt = r_period - r_accel;
      end
      w_ramp_nxt = r_ramp + 32'd1;
    end
    if (w_remaining_nxt != 32'd0) begin
      if ((w_step_state != S_DECEL) && (w_remaining_nxt <= w_ramp_nxt)) begin
        w_step_state = S_DECEL;
        w_period_nxt = f_sat_add(w_period_nxt, r_accel);
        w_ramp_nxt   = w_ramp_nxt - 32'd1;
      end else if (r_state == S_DECEL) begin
        w_period_nxt = f_sat_add(w_period_nxt, r_accel);
        w_ramp_nxt   = (w_ramp_nxt == 32'd0) ? 32'd0 : w_ramp_nxt - 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (r_steps == 32'd0)    w_state_nxt = S_DONE;
          else if (w_cruise_first) w_state_nxt = S_CRUISE;
          else                     w_state_nxt = S_ACCEL;
        end
      end
      S_ACCEL, S_CRUISE, S_DECEL: begin
        if (w_abort)                     w_state_nxt = S_IDLE;
        else if (w_step)                 w_state_nxt = w_step_state;
        else if (r_remaining == 32'd0)   w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_min_eff   <= 32'd0;
      r_period    <= 32'd0;
      r_timer     <= 32'd0;
      r_ramp      <= 32'd0;
      r_remaining <= 32'd0;
      coe_dir     <= 1'b0;
      coe_step    <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      if (w_start) begin
        r_min_eff   <= w_min_eff;
        r_period    <= w_load_period;
        r_timer     <= w_load_period;
        r_ramp      <= 32'd0;
        r_remaining <= r_steps;
        coe_dir     <= avs_ctrl_writedata[2];
      end else if (w_step) begin
        r_period    <= w_period_nxt;
        r_timer     <= w_period_nxt;
        r_ramp      <= w_ramp_nxt;
        r_remaining <= w_remaining_nxt;
      end else if (w_running && (r_timer != 32'd0)) begin
        r_timer <= r_timer - 32'd1;
      end

      // The pulse runs its full width independently of the FSM; only abort cuts it.
      if (w_abort) begin
        coe_step <= 1'b0;
      end else if (w_step) begin
        coe_step    <= 1'b1;
        r_pulse_cnt <= c_PW_LOAD;
      end else if (coe_step) begin
        if (r_pulse_cnt == '0) coe_step <= 1'b0;
        else                   r_pulse_cnt <= r_pulse_cnt - c_PW_W'(1);
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_steps        <= 32'd0;
      r_start_period <= 32'd0;
      r_min_period   <= 32'd0;
      r_accel        <= 32'd0;
      r_ctrl_dir     <= 1'b0;
      r_enable       <= 1'b0;
      r_done         <= 1'b0;
      r_aborted      <= 1'b0;
    end else begin
      if (avs_ctrl_write) begin
        case (avs_ctrl_address)
          3'd0: r_steps        <= f_merge(r_steps, avs_ctrl_writedata, avs_ctrl_byteenable);
          3'd1: r_start_period <= f_merge(r_start_period, avs_ctrl_writedata, avs_ctrl_byteenable);
          3'd2: r_min_period   <= f_merge(r_min_period, avs_ctrl_writedata, avs_ctrl_byteenable);
          3'd3: r_accel        <= f_merge(r_accel, avs_ctrl_writedata, avs_ctrl_byteenable);
          3'd4: begin
            r_ctrl_dir <= avs_ctrl_writedata[2];
            r_enable   <= avs_ctrl_writedata[3];
          end
          default: ;
        endcase
      end
      // Later assignments win, so a set event overrides a same-cycle clear.
      if (w_start || w_status_clr) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) r_done <= 1'b1;
      if (w_abort) r_aborted <= 1'b1;
    end
  end

`ifdef STEP_POSITION_COUNTER_EN
  logic [31:0] r_position;
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset)                                       r_position <= 32'd0;
    else if (avs_ctrl_write && (avs_ctrl_address == 3'd6))    r_position <= avs_ctrl_writedata;
    else if (w_step)                                          r_position <= coe_dir ? r_position + 32'd1
                                                                                    : r_position - 32'd1;
  end
  assign w_position = r_position;
`else
  assign w_position = 32'd0;
`endif

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      avs_ctrl_readdata <= 32'd0;
    end else if (avs_ctrl_read) begin
      case (avs_ctrl_address)
        3'd0:    avs_ctrl_readdata <= r_steps;
        3'd1:    avs_ctrl_readdata <= r_start_period;
        3'd2:    avs_ctrl_readdata <= r_min_period;
        3'd3:    avs_ctrl_readdata <= r_accel;
        3'd4:    avs_ctrl_readdata <= {28'd0, r_enable, r_ctrl_dir, 2'b00};
        3'd5:    avs_ctrl_readdata <= {29'd0, r_aborted, r_done, w_busy};
        3'd6:    avs_ctrl_readdata <= w_position;
        default: avs_ctrl_readdata <= r_remaining;
      endcase
    end
  end
endmodule
`default_nettype wire
